// File: rtl/bram_pkg.sv
// Shared FSM type and index-width helper for the multi-read-port BRAM with hardware clear.
package bram_pkg;

    typedef enum logic {
        BRAM_CLEAR = 1'b0,
        BRAM_READY = 1'b1
    } bram_fsm_t;

    function automatic int BRAM_IDX_W(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bram_read_port.sv
// One registered read port: stage-1 capture, optional stage-2 output register, valid pipeline.
// With BRAM_WR_FWD_EN defined, same-index write bytes are merged into the captured data.
module bram_read_port
    import bram_pkg::*;
#(
    parameter int WIDTH      = 32,
`ifdef BRAM_WR_FWD_EN
    parameter int IDX_W      = 6,
`endif
    parameter int OUTPUT_REG = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ren_i,
    input  logic [WIDTH-1:0]   mem_rdata_i,
`ifdef BRAM_WR_FWD_EN
    input  logic [IDX_W-1:0]   rindex_i,
    input  logic [WIDTH/8-1:0] wen_byte_i,
    input  logic [IDX_W-1:0]   windex_i,
    input  logic [WIDTH-1:0]   wdata_i,
`endif
    output logic [WIDTH-1:0]   rdata_o,
    output logic               rvalid_o
);

    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] s1_data_q;
    logic             s1_valid_q;

`ifdef BRAM_WR_FWD_EN
    logic hit_s;
    assign hit_s = (rindex_i == windex_i);

    // Write-first merge: enabled write bytes override the array output on an index hit
    always_comb begin
        cap_d = mem_rdata_i;
        for (int b = 0; b < WIDTH/8; b++) begin
            cap_d[b*8 +: 8] = (hit_s && wen_byte_i[b]) ? wdata_i[b*8 +: 8] : mem_rdata_i[b*8 +: 8];
        end
    end
`else
    assign cap_d = mem_rdata_i;
`endif

    // Stage 1: data loads only on an accepted read, valid follows the enable
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= ren_i;
            if (ren_i) begin
                s1_data_q <= cap_d;
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] s2_data_q;
            logic             s2_valid_q;

            // Stage 2: holds data when stage 1 is idle, valid drops
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign rdata_o  = s2_data_q;
            assign rvalid_o = s2_valid_q;
        end else begin : g_noreg
            assign rdata_o  = s1_data_q;
            assign rvalid_o = s1_valid_q;
        end
    endgenerate

endmodule

// File: rtl/bram_mrport_1wport_clr.sv
// Multi-read-port, byte-write BRAM with a zeroing sweep after reset or on clear_req.
// Optional macro BRAM_WR_FWD_EN selects write-first read-during-write (default read-first).
module bram_mrport_1wport_clr
    import bram_pkg::*;
#(
    parameter int    WIDTH      = 32,
    parameter int    DEPTH      = 64,
    parameter int    NUM_RPORTS = 2,
    parameter int    OUTPUT_REG = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic                                          CLK,
    input  logic                                          RST,
    input  logic [NUM_RPORTS-1:0]                         ren,
    input  logic [NUM_RPORTS-1:0][BRAM_IDX_W(DEPTH)-1:0]  rindex,
    output logic [NUM_RPORTS-1:0][WIDTH-1:0]              rdata,
    output logic [NUM_RPORTS-1:0]                         rvalid,
    input  logic [WIDTH/8-1:0]                            wen_byte,
    input  logic [BRAM_IDX_W(DEPTH)-1:0]                  windex,
    input  logic [WIDTH-1:0]                              wdata,
    input  logic                                          clear_req,
    output logic                                          ready
);

    localparam int               IDX_W     = BRAM_IDX_W(DEPTH);
    localparam bit               USE_INIT  = (INIT_FILE != "");
    localparam bram_fsm_t        RST_STATE = USE_INIT ? BRAM_READY : BRAM_CLEAR;
    localparam logic [IDX_W-1:0] CNT_LAST  = IDX_W'(DEPTH - 1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    bram_fsm_t             state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [NUM_RPORTS-1:0] ren_s;
    logic [WIDTH/8-1:0]    wen_s;

    // Sweep counter and state sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            BRAM_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = BRAM_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + IDX_W'(1);
                end
            end
            BRAM_READY: begin
                if (clear_req) begin
                    state_d = BRAM_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = BRAM_READY;
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == BRAM_READY);
    end

    // FSM, counter and ready registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign ren_s = ren & {NUM_RPORTS{ready_q}};
    assign wen_s = wen_byte & {(WIDTH/8){ready_q}};

    // Array write: the sweep owns the port while clearing; contents survive RST
    always_ff @(posedge CLK) begin
        if (state_q == BRAM_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int b = 0; b < WIDTH/8; b++) begin
                if (wen_s[b]) begin
                    mem_q[windex][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
            bram_read_port #(
                .WIDTH      (WIDTH),
`ifdef BRAM_WR_FWD_EN
                .IDX_W      (IDX_W),
`endif
                .OUTPUT_REG (OUTPUT_REG)
            ) u_rport (
                .clk_i       (CLK),
                .rst_i       (RST),
                .ren_i       (ren_s[p]),
                .mem_rdata_i (mem_q[rindex[p]]),
`ifdef BRAM_WR_FWD_EN
                .rindex_i    (rindex[p]),
                .wen_byte_i  (wen_s),
                .windex_i    (windex),
                .wdata_i     (wdata),
`endif
                .rdata_o     (rdata[p]),
                .rvalid_o    (rvalid[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_bram_mrport_1wport_clr.sv
// Scoreboard bench: two DUTs (OUTPUT_REG 0 and 1) share stimulus; a behavioural model queues expected reads.
module tb_bram_mrport_1wport_clr;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int NP    = 2;
    localparam int IDX_W = 6;
    localparam int NB    = WIDTH / 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NP-1:0]             ren;
    logic [NP-1:0][IDX_W-1:0]  rindex;
    logic [NB-1:0]             wen_byte;
    logic [IDX_W-1:0]          windex;
    logic [WIDTH-1:0]          wdata;
    logic                      clear_req;
    logic [NP-1:0][WIDTH-1:0]  rdata0, rdata1;
    logic [NP-1:0]             rvalid0, rvalid1;
    logic                      ready0, ready1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bram_mrport_1wport_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RPORTS(NP), .OUTPUT_REG(0), .INIT_FILE("")) u_dut0 (
        .CLK(clk), .RST(rst), .ren(ren), .rindex(rindex), .rdata(rdata0), .rvalid(rvalid0),
        .wen_byte(wen_byte), .windex(windex), .wdata(wdata), .clear_req(clear_req), .ready(ready0));

    bram_mrport_1wport_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RPORTS(NP), .OUTPUT_REG(1), .INIT_FILE("")) u_dut1 (
        .CLK(clk), .RST(rst), .ren(ren), .rindex(rindex), .rdata(rdata1), .rvalid(rvalid1),
        .wen_byte(wen_byte), .windex(windex), .wdata(wdata), .clear_req(clear_req), .ready(ready1));

    typedef struct packed {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t             exp_q [2*NP][$];
    logic [WIDTH-1:0] mmem [DEPTH];
    logic [WIDTH-1:0] last_d [2*NP];
    int               m_left = DEPTH;
    bit               m_ready = 1'b0;
    int               cyc = 0;
    logic [WIDTH-1:0] mv;
    exp_t             me;
    logic             mon_v;
    logic [WIDTH-1:0] mon_d;
    exp_t             mon_e;

    task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: sweep takes DEPTH cycles, then reads see pre-write contents (or merged bytes when forwarding)
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_left = DEPTH;
            for (int k = 0; k < 2*NP; k++) exp_q[k].delete();
        end else if (m_left == 0) begin
            for (int p = 0; p < NP; p++) begin
                if (ren[p]) begin
                    mv = mmem[rindex[p]];
`ifdef BRAM_WR_FWD_EN
                    if (rindex[p] == windex) begin
                        for (int b = 0; b < NB; b++) if (wen_byte[b]) mv[b*8 +: 8] = wdata[b*8 +: 8];
                    end
`endif
                    me.data = mv;
                    me.due  = cyc;
                    exp_q[p].push_back(me);
                    me.due  = cyc + 1;
                    exp_q[NP+p].push_back(me);
                end
            end
            for (int b = 0; b < NB; b++) if (wen_byte[b]) mmem[windex][b*8 +: 8] = wdata[b*8 +: 8];
            if (clear_req) m_left = DEPTH;
        end else begin
            mmem[DEPTH - m_left] = '0;
            m_left--;
        end
        m_ready = (m_left == 0);
    end

    // Monitor: pops the scoreboard whenever a DUT port presents rvalid
    always @(negedge clk) begin
        if (rst) begin
            check("rst_ready0", {31'd0, ready0}, 32'd0);
            check("rst_ready1", {31'd0, ready1}, 32'd0);
            check("rst_rvalid", {28'd0, rvalid1, rvalid0}, 32'd0);
            for (int k = 0; k < 2*NP; k++) last_d[k] = '0;
        end else begin
            check("ready0", {31'd0, ready0}, {31'd0, m_ready});
            check("ready1", {31'd0, ready1}, {31'd0, m_ready});
            for (int k = 0; k < 2*NP; k++) begin
                if (k < NP) begin
                    mon_v = rvalid0[k];
                    mon_d = rdata0[k];
                end else begin
                    mon_v = rvalid1[k-NP];
                    mon_d = rdata1[k-NP];
                end
                if (mon_v) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("dut%0d_p%0d_spurious_rvalid", k/NP, k%NP), 32'd1, 32'd0);
                    end else begin
                        mon_e = exp_q[k].pop_front();
                        check($sformatf("dut%0d_p%0d_latency", k/NP, k%NP), WIDTH'(cyc), WIDTH'(mon_e.due));
                        check($sformatf("dut%0d_p%0d_rdata", k/NP, k%NP), mon_d, mon_e.data);
                        last_d[k] = mon_e.data;
                    end
                end else begin
                    check($sformatf("dut%0d_p%0d_hold", k/NP, k%NP), mon_d, last_d[k]);
                    if (exp_q[k].size() != 0 && exp_q[k][0].due <= cyc) begin
                        check($sformatf("dut%0d_p%0d_missing_rvalid", k/NP, k%NP), 32'd0, 32'd1);
                        void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        ren       = '0;
        rindex    = '0;
        wen_byte  = '0;
        windex    = '0;
        wdata     = '0;
        clear_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (ready0 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(nm, WIDTH'(n), WIDTH'(DEPTH));
    endtask

    task automatic wr(input logic [IDX_W-1:0] idx, input logic [NB-1:0] be, input logic [WIDTH-1:0] d);
        windex   = idx;
        wen_byte = be;
        wdata    = d;
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        wait_ready("ready_rise_after_reset");

        ren = 2'b11; rindex[0] = 6'd0; rindex[1] = 6'd31; tick();
        ren = 2'b01; rindex[0] = 6'd63; tick();

        wr(6'd5, 4'b1111, 32'hDEADBEEF); tick();
        wr(6'd5, 4'b0010, 32'h0000AA00); tick();
        ren = 2'b11; rindex[0] = 6'd5; rindex[1] = 6'd5; tick();

        wr(6'd9, 4'b1111, 32'h11111111); tick();
        wr(6'd9, 4'b0101, 32'h22222222); ren = 2'b01; rindex[0] = 6'd9; tick();
        ren = 2'b10; rindex[1] = 6'd9; tick();

        wr(6'd3, 4'b1111, 32'hCAFEF00D); tick();
        ren = 2'b10; rindex[1] = 6'd3; tick();
        repeat (3) tick();

        wr(6'd7, 4'b1111, 32'h12345678); clear_req = 1'b1; tick();
        n = 0;
        while (ready0 !== 1'b1 && n < 200) begin
            wr(6'd7, 4'b1111, $urandom);
            ren = 2'b11; rindex[0] = 6'd7; rindex[1] = 6'd5;
            tick();
            n++;
        end
        check("clear_req_sweep_len", WIDTH'(n), WIDTH'(DEPTH));
        ren = 2'b11; rindex[0] = 6'd7; rindex[1] = 6'd7; tick();
        repeat (3) tick();

        for (int i = 0; i < 400; i++) begin
            ren = 2'($urandom_range(0, 3));
            for (int p = 0; p < NP; p++)
                rindex[p] = ($urandom_range(0, 1) == 0) ? IDX_W'($urandom_range(0, 7)) : IDX_W'($urandom_range(0, DEPTH-1));
            wr(IDX_W'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom);
            clear_req = ($urandom_range(0, 149) == 0);
            tick();
        end
        repeat (70) tick();

        rst = 1'b1; tick();
        rst = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        #1;
        check("mid_sweep_rst_ready", {30'd0, ready1, ready0}, 32'd0);
        check("mid_sweep_rst_rvalid", {28'd0, rvalid1, rvalid0}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        wait_ready("ready_rise_after_mid_sweep_rst");

        ren = 2'b11; rindex[0] = 6'd9; rindex[1] = 6'd63; tick();
        repeat (4) tick();
        for (int k = 0; k < 2*NP; k++)
            check($sformatf("scoreboard_drained_%0d", k), WIDTH'(exp_q[k].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_mrport_1wport_clr.md
Name: bram_mrport_1wport_clr

Overview:
- Parametrised successor to the single-read/single-write BRAM primitive.
- Provides NUM_RPORTS independent registered read ports, one byte-enabled write port, and an optional second output register stage.
- Includes a hardware clear sequencer that zeroes the array after reset or on request.
- Used for predictor tables, tag arrays and register-file-style storage that must come up clean without an init file.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 64, number of entries; must be a power of 2, at least 2.
- NUM_RPORTS, 2, number of read ports; range 1..8.
- OUTPUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- INIT_FILE, "", hex init file; if non-empty, the post-reset clear sweep is skipped and the array is loaded via $readmemh.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- ren  in  NUM_RPORTS  per-port read enable.
- rindex  in  NUM_RPORTS x clog2(DEPTH)  per-port read index (packed array).
- rdata  out  NUM_RPORTS x WIDTH  per-port read data.
- rvalid  out  NUM_RPORTS  per-port read data valid.
- wen_byte  in  WIDTH/8  write byte enables.
- windex  in  clog2(DEPTH)  write index.
- wdata  in  WIDTH  write data.
- clear_req  in  1  request a full zeroing sweep.
- ready  out  1  array accepts reads and writes.

Behaviour:
- Single clock domain. RST is asynchronous, active-high. The array contents are not reset by RST.
- Reset values:
  - rdata = 0, rvalid = 0 on all ports and all pipeline stages.
  - ready = 0, clear counter = 0.
  - FSM = CLEAR if INIT_FILE == "", else READY.
- FSM states:
  - CLEAR:
    - Each cycle writes 0 to array[cnt] and increments cnt.
    - At cnt == DEPTH-1, performs the final write, moves to READY and resets cnt to 0.
    - The sweep takes exactly DEPTH cycles.
    - ready = 0. ren, wen_byte and clear_req are ignored.
  - READY:
    - ready = 1. Ports operate normally.
    - clear_req = 1 moves to CLEAR next cycle with cnt = 0.
    - A write or read presented in the same cycle as clear_req is still performed.
- Read, OUTPUT_REG = 0:
  - ren[p] with ready = 1 at cycle t gives rdata[p] = array[rindex[p]] and rvalid[p] = 1 at t+1.
  - ren[p] = 0 gives rvalid[p] = 0 next cycle, and rdata[p] holds its last value.
- Read, OUTPUT_REG = 1:
  - One extra stage; data and valid appear at t+2.
  - The second stage loads only when the first-stage valid is 1, otherwise it holds data and clears valid.
- Reads issued before entry to CLEAR complete normally through the pipeline.
- Write:
  - At the posedge, array[windex] byte b <= wdata byte b for each b where wen_byte[b] = 1 and ready = 1.
- Read-during-write, same index, same cycle:
  - Default is read-first: returns the pre-write contents.
  - See Optional Feature for the forwarding behaviour.
- Multiple read ports may read the same index in the same cycle. All receive identical data.
- RST asserted mid-sweep or mid-read: FSM, counter and pipelines return to reset values immediately. Partially cleared entries remain. The sweep restarts from 0 after RST deasserts.

Optional Feature:
- Macro: BRAM_WR_FWD_EN.
- Defined: on a same-cycle read and write to the same index, the captured read data is a per-byte merge. Bytes with wen_byte set come from wdata; the rest come from the array. This is write-first behaviour on every port.
- Undefined: read-first. The array output is captured unmodified, and no comparator or merge logic is generated.

Decomposition:
- Package bram_pkg:
  - bram_fsm_t enum {BRAM_CLEAR, BRAM_READY}.
  - Localparam helper BRAM_IDX_W(DEPTH) = clog2(DEPTH).
- Sub-module bram_read_port, instantiated NUM_RPORTS times by generate. It holds:
  - the per-port stage-1 and stage-2 registers;
  - the valid pipeline;
  - the forwarding compare/merge when BRAM_WR_FWD_EN is defined.
- Top level holds:
  - the array;
  - the write port and the clear write mux;
  - the FSM and counter.

Test Plan:
- Reset, then let the sweep run (DEPTH = 64, INIT_FILE = "").
  - ready rises exactly 64 cycles after RST falls.
  - Reading index 0, 31 and 63 then returns 0x00000000 with rvalid one cycle later.
- Write index 5 = 0xDEADBEEF with wen_byte = 4'b1111, then 4'b0010 with 0x0000AA00.
  - A read of 5 on both ports returns 0xDEADAAEF.
- Same-cycle write and read of index 9.
  - Setup: old value 0x11111111; write 0x22222222 with wen_byte = 4'b0101.
  - With BRAM_WR_FWD_EN defined: read returns 0x11221122.
  - Without it: read returns 0x11111111.
  - The next read returns 0x11221122 in both builds.
- OUTPUT_REG = 1: ren on port 1 at cycle t for index 3 holding 0xCAFEF00D.
  - rvalid[1] = 1 and rdata[1] = 0xCAFEF00D at t+2 only.
  - Port 0 with ren = 0 keeps rvalid[0] = 0.
- clear_req pulsed in READY while writing 0x12345678 to index 7.
  - ready = 0 for 64 cycles; writes during the sweep have no effect.
  - Afterwards index 7 reads 0.
- RST asserted at cycle 20 of the sweep.
  - rvalid = 0 and ready = 0 immediately.
  - After release the sweep restarts and ready rises 64 cycles later.
